stconv_ctl: RTL and testbench



---
 rtl/stconv_pkg.sv | 19 +
 rtl/stconv_align.sv | 32 +++
 rtl/stconv_ctl.sv | 133 +++++++++++++
 tb/tb_stconv_ctl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stconv_pkg.sv
// Shared definitions for the store-path converter: store funct3 codes and FSM states.
package stconv_pkg;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2,
      ST_FIN   = 2'd3
   } stconv_state_e;

   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
   endfunction

endpackage

// File: rtl/stconv_align.sv
// Combinational store aligner: masks the stored bytes and shifts data and byte enables
// across a two-word (64-bit) window so the caller can split straddling stores.
module stconv_align
   import stconv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] data,
   output logic [7:0]  be8,
   output logic [63:0] d64
);

   logic [3:0]  mask;
   logic [31:0] dmask;

   always_comb begin
      case (funct3)
         F3_SB:   mask = 4'b0001;
         F3_SH:   mask = 4'b0011;
         F3_SW:   mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      // Unstored bytes are zeroed before the shift so disabled lanes read 0.
      dmask = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         dmask[8*i +: 8] = mask[i] ? data[8*i +: 8] : 8'h00;
      end
      be8 = {4'b0000, mask} << offset;
      d64 = {32'h0000_0000, dmask} << {offset, 3'b000};
   end

endmodule

// File: rtl/stconv_ctl.sv
// Store data converter: captures a store request, aligns it into word lanes and drives
// one or two word-aligned write beats on the data-memory handshake.
module stconv_ctl
   import stconv_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] ir,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        mem_req,
   input  logic        mem_ack,
   output logic        busy,
   output logic        done,
   output logic        err
);

   stconv_state_e state;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;
   logic [31:0]   wdata_q;

   logic [2:0]    sel_f3;
   logic [1:0]    sel_off;
   logic [31:0]   sel_data;
   logic [7:0]    be8;
   logic [63:0]   d64;
   logic          unused_ir;

   assign unused_ir = ^{ir[31:15], ir[11:0]};

   // In IDLE the aligner sees the live request so beat 0 can be registered on the
   // accepting edge; afterwards it only sees the captured copy.
   always_comb begin
      if (state == ST_IDLE) begin
         sel_f3   = ir[14:12];
         sel_off  = addr[1:0];
         sel_data = wdata;
      end else begin
         sel_f3   = f3_q;
         sel_off  = off_q;
         sel_data = wdata_q;
      end
   end

   stconv_align u_align (
      .funct3 (sel_f3),
      .offset (sel_off),
      .data   (sel_data),
      .be8    (be8),
      .d64    (d64)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         f3_q      <= '0;
         off_q     <= '0;
         wdata_q   <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         mem_req   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  f3_q    <= ir[14:12];
                  off_q   <= addr[1:0];
                  wdata_q <= wdata;
                  busy    <= 1'b1;
                  if (f3_legal(ir[14:12])) begin
                     state     <= ST_BEAT0;
                     mem_req   <= 1'b1;
                     mem_addr  <= {addr[31:2], 2'b00};
                     mem_be    <= be8[3:0];
                     mem_wdata <= d64[31:0];
                  end else begin
                     state <= ST_FIN;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end
               end
            end
            ST_BEAT0: begin
               if (mem_ack) begin
                  if (be8[7:4] != 4'b0000) begin
                     state     <= ST_BEAT1;
                     mem_addr  <= mem_addr + 32'd4;
                     mem_be    <= be8[7:4];
                     mem_wdata <= d64[63:32];
                  end else begin
                     state     <= ST_FIN;
                     mem_req   <= 1'b0;
                     mem_addr  <= '0;
                     mem_be    <= '0;
                     mem_wdata <= '0;
                     done      <= 1'b1;
                  end
               end
            end
            ST_BEAT1: begin
               if (mem_ack) begin
                  state     <= ST_FIN;
                  mem_req   <= 1'b0;
                  mem_addr  <= '0;
                  mem_be    <= '0;
                  mem_wdata <= '0;
                  done      <= 1'b1;
               end
            end
            ST_FIN: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stconv_ctl.sv
// Self-checking bench for stconv_ctl: directed and random stores compared against a
// byte-by-byte reference model of the memory words each store touches.
module tb_stconv_ctl;

   logic        clock;
   logic        reset;
   logic        start;
   logic [31:0] ir;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_req;
   logic        mem_ack;
   logic        busy;
   logic        done;
   logic        err;

   stconv_ctl dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .ir        (ir),
      .addr      (addr),
      .wdata     (wdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_req   (mem_req),
      .mem_ack   (mem_ack),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   int unsigned exp_n;
   logic [31:0] exp_addr [2];
   logic [3:0]  exp_be   [2];
   logic [31:0] exp_wd   [2];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Reference: place each stored byte at its own byte address and group by word.
   task automatic model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int unsigned nb;
      int unsigned b;
      int unsigned lane;
      logic [31:0] base;
      logic [31:0] ba;
      nb = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
      base = a & ~32'h3;
      exp_addr[0] = base;
      exp_addr[1] = base + 32'd4;
      for (int k = 0; k < 2; k++) begin
         exp_be[k] = '0;
         exp_wd[k] = '0;
      end
      for (int unsigned i = 0; i < nb; i++) begin
         ba   = a + i;
         b    = ((ba & ~32'h3) == base) ? 0 : 1;
         lane = ba[1:0];
         exp_be[b][lane]       = 1'b1;
         exp_wd[b][8*lane +: 8] = d[8*i +: 8];
      end
      exp_n = (nb == 0) ? 0 : (exp_be[1] != 4'b0000) ? 2 : 1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".req"},  {31'b0, mem_req}, 32'd0);
      check({tag, ".busy"}, {31'b0, busy},    32'd0);
      check({tag, ".done"}, {31'b0, done},    32'd0);
      check({tag, ".err"},  {31'b0, err},     32'd0);
   endtask

   task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] r;
      model(f3, a, d);
      @(negedge clock);
      r = $urandom;
      r[14:12] = f3;
      ir    = r;
      addr  = a;
      wdata = d;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      ir    = $urandom;
      addr  = $urandom;
      wdata = $urandom;
   endtask

   // Runs one store; dly = cycles each beat waits for ack, poke = pulse start while busy.
   task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input int unsigned dly, input bit poke);
      logic [31:0] r;
      launch(f3, a, d);
      if (exp_n == 0) begin
         check({tag, ".ill_done"}, {31'b0, done},    32'd1);
         check({tag, ".ill_err"},  {31'b0, err},     32'd1);
         check({tag, ".ill_req"},  {31'b0, mem_req}, 32'd0);
      end else begin
         for (int unsigned b = 0; b < exp_n; b++) begin
            for (int unsigned c = 0; c <= dly; c++) begin
               check({tag, ".req"},   {31'b0, mem_req}, 32'd1);
               check({tag, ".busy"},  {31'b0, busy},    32'd1);
               check({tag, ".done"},  {31'b0, done},    32'd0);
               check({tag, ".addr"},  mem_addr,         exp_addr[b]);
               check({tag, ".be"},    {28'b0, mem_be},  {28'b0, exp_be[b]});
               check({tag, ".wdata"}, mem_wdata,        exp_wd[b]);
               mem_ack = (c == dly);
               if (poke && b == 0 && c == 0) begin
                  r = $urandom;
                  r[14:12] = 3'b010;
                  ir    = r;
                  start = 1'b1;
               end
               @(negedge clock);
               start = 1'b0;
            end
         end
         mem_ack = 1'b0;
         check({tag, ".fin_done"}, {31'b0, done},    32'd1);
         check({tag, ".fin_err"},  {31'b0, err},     32'd0);
         check({tag, ".fin_req"},  {31'b0, mem_req}, 32'd0);
      end
      mem_ack = $urandom;
      @(negedge clock);
      check_idle({tag, ".after"});
      mem_ack = 1'b0;
   endtask

   initial begin
      int unsigned r;
      logic [2:0]  f3;
      reset   = 1'b0;
      start   = 1'b0;
      ir      = '0;
      addr    = '0;
      wdata   = '0;
      mem_ack = 1'b0;
      #12;
      check_idle("rst");
      check("rst.addr",  mem_addr,  32'd0);
      check("rst.wdata", mem_wdata, 32'd0);
      check("rst.be",    {28'b0, mem_be}, 32'd0);
      @(negedge clock);
      reset = 1'b1;

      run_store("sb",    3'b000, 32'h0000_1003, 32'h1234_56AB, 0, 1'b0);
      run_store("sh",    3'b001, 32'h0000_2002, 32'hFFFF_BEEF, 3, 1'b0);
      run_store("sw",    3'b010, 32'h0000_3001, 32'hDDCC_BBAA, 0, 1'b0);
      run_store("wrap",  3'b001, 32'hFFFF_FFFF, 32'h0000_5A3C, 1, 1'b0);
      run_store("ill",   3'b011, 32'h0000_4000, 32'h1111_2222, 0, 1'b0);
      run_store("poke",  3'b010, 32'h0000_5002, 32'h8765_4321, 2, 1'b1);

      // Reset during beat 1 of a split word store.
      launch(3'b010, 32'h0000_3001, 32'hDDCC_BBAA);
      mem_ack = 1'b1;
      @(negedge clock);
      check("mid.beat1_addr", mem_addr, exp_addr[1]);
      #2;
      reset = 1'b0;
      #1;
      check_idle("mid");
      check("mid.addr",  mem_addr,  32'd0);
      check("mid.wdata", mem_wdata, 32'd0);
      check("mid.be",    {28'b0, mem_be}, 32'd0);
      @(negedge clock);
      reset   = 1'b1;
      mem_ack = 1'b0;
      @(negedge clock);
      check_idle("post_rst");
      run_store("post", 3'b000, 32'h0000_6001, 32'h0000_00C3, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         r  = $urandom_range(0, 9);
         f3 = (r < 8) ? 3'(r % 3) : 3'(3 + $urandom_range(0, 4));
         run_store("rnd", f3, $urandom, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
